reg_readback: RTL

REG_READBACK -- requirements
Module: reg_readback

---
 rtl/rsnn_pkg.sv | 18 +
 rtl/readback_shifter.sv | 42 ++++
 rtl/reg_readback.sv | 84 ++++++++
 3 files changed

// File: rtl/rsnn_pkg.sv
// rtl/rsnn_pkg.sv - shared state encoding and default sizes for the register readback path
package rsnn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } rb_state_t;

  localparam int DEF_WIDTH    = 3;
  localparam int DEF_NUM_REGS = 4;

  // Counter width that stays at least one bit wide for a count of one.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/readback_shifter.sv
// rtl/readback_shifter.sv - shadow copy of the register bank with MSB-first bit select
module readback_shifter
  import rsnn_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int NUM_REGS = DEF_NUM_REGS
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load,
  input  logic [NUM_REGS*WIDTH-1:0]     data,
  input  logic [cnt_w(NUM_REGS)-1:0]    reg_idx,
  input  logic [cnt_w(WIDTH)-1:0]       bit_cnt,
  output logic                          bit_out
);

  localparam int BW = cnt_w(WIDTH);
  localparam int IW = cnt_w(NUM_REGS);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  logic [NUM_REGS*WIDTH-1:0] shadow;
  logic [WIDTH-1:0]          cur;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
    end else if (load) begin
      shadow <= data;
    end
  end

  always_comb begin
    cur = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (reg_idx == IW'(i)) cur = shadow[WIDTH*i +: WIDTH];
    end
  end

  // bit_cnt counts from the MSB downwards, so position = WIDTH-1 - bit_cnt
  assign bit_out = cur[BIT_LAST - bit_cnt];

endmodule

// File: rtl/reg_readback.sv
// rtl/reg_readback.sv - serialises a snapshot of NUM_REGS registers, MSB first, with backpressure
module reg_readback
  import rsnn_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int NUM_REGS = DEF_NUM_REGS
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [NUM_REGS*WIDTH-1:0]     regs_in,
  input  logic                          out_ready,
  output logic                          sout,
  output logic                          sout_valid,
  output logic                          reg_first,
  output logic [cnt_w(NUM_REGS)-1:0]    reg_idx,
  output logic                          busy,
  output logic                          done
);

  localparam int BW = cnt_w(WIDTH);
  localparam int IW = cnt_w(NUM_REGS);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [IW-1:0] REG_LAST = IW'(NUM_REGS - 1);

  rb_state_t       state;
  logic [BW-1:0]   bit_cnt;
  logic            load;
  logic            msb;

  assign load = (state == ST_IDLE) && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      reg_idx <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_SHIFT;
            bit_cnt <= '0;
            reg_idx <= '0;
          end
        end
        ST_SHIFT: begin
          if (out_ready) begin
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
              // last register ends the frame rather than wrapping reg_idx
              if (reg_idx == REG_LAST) state <= ST_DONE;
              else                     reg_idx <= reg_idx + IW'(1);
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  readback_shifter #(
    .WIDTH    (WIDTH),
    .NUM_REGS (NUM_REGS)
  ) u_shifter (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .data    (regs_in),
    .reg_idx (reg_idx),
    .bit_cnt (bit_cnt),
    .bit_out (msb)
  );

  assign sout_valid = (state == ST_SHIFT);
  assign sout       = sout_valid & msb;
  assign reg_first  = sout_valid && (bit_cnt == '0);
  assign busy       = (state != ST_IDLE);
  assign done       = (state == ST_DONE);

endmodule
